// File: rtl/sobel_stream_acc.sv
// sobel_stream_acc: streams an 8-bit greyscale image from word memory through a 3x3 Sobel operator and writes the result image back.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   addr          word address of the current memory request
//   dataR         read data, valid the cycle after a read is issued
//   dataW         write data, zero whenever we=0
//   en, we        memory request and write strobe
//   start         level-sampled job request, honoured in IDLE and DONE
//   finish        high while the completed job is held in DONE
module sobel_stream_acc #(
    parameter int IMG_WIDTH  = 352,
    parameter int IMG_HEIGHT = 288,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 25344,
    parameter int MODE       = 0,
    parameter int THRESHOLD  = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] addr,
    input  logic [31:0] dataR,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    input  logic        start,
    output logic        finish
);
    localparam int WORDS = IMG_WIDTH / 4 * IMG_HEIGHT;
    localparam logic [15:0] WPR = 16'(IMG_WIDTH / 4);
    localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] SRC = 16'(SRC_BASE);
    localparam logic [15:0] DST = 16'(DST_BASE);
    localparam logic [11:0] THR = 12'(THRESHOLD);

    if (SRC_BASE < DST_BASE + WORDS && DST_BASE < SRC_BASE + WORDS) begin : g_overlap
        $error("sobel_stream_acc: source and result regions overlap");
    end

    typedef enum logic [3:0] {IDLE, BTOP, RD0, RD1, RD2, CAP, LAST, BBOT, DONE} state_t;
    state_t state, state_n;
    logic [15:0] y, c, row, col;
    logic [31:0] cap_u, cap_m, res;
    logic [2:0][31:0] win_c, fresh;
    logic [2:0][7:0] win_l;
    logic [2:0][47:0] strip;
    logic wr_res;

    // Each row argument holds L (bits 7:0), C (15:8) and R (23:16); the
    // two's-complement wrap of 11-bit arithmetic gives the signed gradients.
    function automatic logic [7:0] sobel(input logic [23:0] u, input logic [23:0] m, input logic [23:0] d);
        logic [10:0] gx, gy, ax, ay;
        logic [11:0] mag;
        gx = {3'b0, u[23:16]} + {2'b0, m[23:16], 1'b0} + {3'b0, d[23:16]}
           - {3'b0, u[7:0]} - {2'b0, m[7:0], 1'b0} - {3'b0, d[7:0]};
        gy = {3'b0, d[7:0]} + {2'b0, d[15:8], 1'b0} + {3'b0, d[23:16]}
           - {3'b0, u[7:0]} - {2'b0, u[15:8], 1'b0} - {3'b0, u[23:16]};
        ax = gx[10] ? -gx : gx;
        ay = gy[10] ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};
        return MODE == 1 ? (mag >= THR ? 8'hff : 8'h00) : (mag > 12'd255 ? 8'hff : mag[7:0]);
    endfunction

    // Result word col is built from a 6-pixel strip per row: the last pixel of
    // word col-1, word col itself and the first pixel of word col+1 (zero in LAST).
    always_comb begin
        fresh = {dataR, cap_m, cap_u};
        col = state == LAST ? WPR - 16'd1 : c - 16'd1;
        strip = '0;
        res = '0;
        for (int r = 0; r < 3; r++)
            strip[r] = {state == CAP ? fresh[r][7:0] : 8'h00, win_c[r], win_l[r]};
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sobel(strip[0][8*b +: 24], strip[1][8*b +: 24], strip[2][8*b +: 24]);
        if (col == 16'd0) res[7:0] = 8'h00;
        if (col == WPR - 16'd1) res[31:24] = 8'h00;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? BTOP : state;
            BTOP:       state_n = c == WPR - 16'd1 ? RD0 : BTOP;
            RD0:        state_n = RD1;
            RD1:        state_n = RD2;
            RD2:        state_n = CAP;
            CAP:        state_n = c == WPR - 16'd1 ? LAST : RD0;
            LAST:       state_n = y < LAST_ROW - 16'd1 ? RD0 : BBOT;
            BBOT:       state_n = c == WPR - 16'd1 ? DONE : BBOT;
            default:    state_n = IDLE;
        endcase
        wr_res = state == LAST || (state == CAP && c != 16'd0);
        en = wr_res || state inside {BTOP, RD0, RD1, RD2, BBOT};
        we = wr_res || state inside {BTOP, BBOT};
        finish = state == DONE;
        row = state == RD0 ? y - 16'd1 : state == RD2 ? y + 16'd1 :
              state == BBOT ? LAST_ROW : state == BTOP ? 16'd0 : y;
        addr = en ? (state inside {RD0, RD1, RD2} ? SRC : DST) + row * WPR + (wr_res ? col : c) : 16'd0;
        dataW = wr_res ? res : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
            c <= '0;
            cap_u <= '0;
            cap_m <= '0;
            win_c <= '0;
            win_l <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    y <= start ? 16'd0 : y;
                    c <= start ? 16'd0 : c;
                end
                BTOP: begin
                    c <= c == WPR - 16'd1 ? 16'd0 : c + 16'd1;
                    y <= 16'd1;
                end
                RD1: cap_u <= dataR;
                RD2: cap_m <= dataR;
                CAP: begin
                    win_l <= {win_c[2][31:24], win_c[1][31:24], win_c[0][31:24]};
                    win_c <= fresh;
                    c <= c == WPR - 16'd1 ? c : c + 16'd1;
                end
                LAST: begin
                    c <= 16'd0;
                    y <= y + 16'd1;
                end
                BBOT: c <= c == WPR - 16'd1 ? 16'd0 : c + 16'd1;
                default: ;
            endcase
        end
    end
endmodule
